// File: rtl/lfsr_prime_gen_pkg.sv
// Shared types and constants for the LFSR-driven prime source.
// Holds the controller state encoding and the default Galois tap masks for each supported width.
package lfsr_prime_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_BOUND,
    STEP,
    RANGE,
    DIV_TEST,
    DIV_SUB,
    DONE,
    FAIL
  } state_t;

  localparam logic [6:0]  TAPS_W7  = 7'h60;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  // Maximal-length tap masks; unknown widths fall back to the 7-bit mask.
  function automatic logic [15:0] default_taps(input int w);
    case (w)
      8:       return 16'(TAPS_W8);
      16:      return TAPS_W16;
      default: return 16'(TAPS_W7);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with seed load and step enable.
// A zero load value is replaced by 1 so the register can never lock up at zero.
module lfsr_galois #(
  parameter int              WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = 7'h60,
  parameter logic [WIDTH-1:0] SEED  = 7'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign next[gi] = state[gi+1] ^ (state[0] & TAPS[gi]);
    end
  endgenerate
  assign next[WIDTH-1] = state[0] & TAPS[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else if (step) begin
      state <= next;
    end
  end

endmodule

// File: rtl/lfsr_prime_gen.sv
// Prime source: walks a Galois LFSR until a value lands in [2, score], then proves it
// prime by trial division using repeated subtraction; fails when the bound or try budget runs out.
module lfsr_prime_gen
  import lfsr_prime_gen_pkg::*;
#(
  parameter int               WIDTH     = 7,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int               MAX_TRIES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] score,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic             busy,
  output logic             valid,
  output logic             fail,
  output logic [WIDTH-1:0] primeNumberOutput
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  state_t           state_reg;
  logic [WIDTH-1:0] limit_reg;
  logic [WIDTH-1:0] cand_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [TW-1:0]    tries_reg;

  logic [WIDTH-1:0]   lfsr_val;
  logic               step_en;
  logic               load_en;
  logic [2*WIDTH-1:0] d_sq;
  logic               tries_done;

  assign tries_done = (tries_reg == TW'(MAX_TRIES));
  assign step_en    = (state_reg == STEP) && !tries_done;
  assign load_en    = (state_reg == IDLE) && seed_load;
  // Full double-width square so the stop test cannot wrap for large divisors.
  assign d_sq       = {{WIDTH{1'b0}}, d_reg} * {{WIDTH{1'b0}}, d_reg};

  lfsr_galois #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (step_en),
    .load     (load_en),
    .load_val (seed),
    .state    (lfsr_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      limit_reg         <= '0;
      cand_reg          <= '0;
      d_reg             <= '0;
      r_reg             <= '0;
      tries_reg         <= '0;
      busy              <= 1'b0;
      valid             <= 1'b0;
      fail              <= 1'b0;
      primeNumberOutput <= '0;
    end else begin
      valid <= 1'b0;
      fail  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!seed_load && enable) begin
            limit_reg <= score;
            tries_reg <= '0;
            busy      <= 1'b1;
            state_reg <= CHK_BOUND;
          end
        end
        CHK_BOUND: state_reg <= (limit_reg < WIDTH'(2)) ? FAIL : STEP;
        STEP: begin
          if (tries_done) begin
            state_reg <= FAIL;
          end else begin
            tries_reg <= tries_reg + TW'(1);
            state_reg <= RANGE;
          end
        end
        RANGE: begin
          cand_reg <= lfsr_val;
          if (lfsr_val < WIDTH'(2) || lfsr_val > limit_reg) begin
            state_reg <= STEP;
          end else begin
            d_reg     <= WIDTH'(2);
            state_reg <= DIV_TEST;
          end
        end
        DIV_TEST: begin
          if (d_sq > {{WIDTH{1'b0}}, cand_reg}) begin
            state_reg <= DONE;
          end else begin
            r_reg     <= cand_reg;
            state_reg <= DIV_SUB;
          end
        end
        DIV_SUB: begin
          // r reduces to (cand mod d); zero remainder means a divisor was found.
          if (r_reg >= d_reg) begin
            r_reg <= r_reg - d_reg;
          end else if (r_reg == '0) begin
            state_reg <= STEP;
          end else begin
            d_reg     <= d_reg + WIDTH'(1);
            state_reg <= DIV_TEST;
          end
        end
        DONE: begin
          primeNumberOutput <= cand_reg;
          valid             <= 1'b1;
          busy              <= 1'b0;
          state_reg         <= IDLE;
        end
        FAIL: begin
          fail      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_prime_gen.sv
// Directed bench for lfsr_prime_gen: default instance plus a MAX_TRIES=4 instance sharing stimulus.
module tb_lfsr_prime_gen;
  import lfsr_prime_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [6:0] score;
  logic       seed_load;
  logic [6:0] seed;
  logic       busy, valid, fail;
  logic [6:0] prime;
  logic       busy4, valid4, fail4;
  logic [6:0] prime4;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0, step_cnt4 = 0;
  int vcnt = 0, fcnt = 0;

  lfsr_prime_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .score(score),
    .seed_load(seed_load), .seed(seed),
    .busy(busy), .valid(valid), .fail(fail), .primeNumberOutput(prime)
  );

  lfsr_prime_gen #(.MAX_TRIES(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .score(score),
    .seed_load(seed_load), .seed(seed),
    .busy(busy4), .valid(valid4), .fail(fail4), .primeNumberOutput(prime4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && dut.step_en)  step_cnt++;
    if (!rst && dut4.step_en) step_cnt4++;
    if (valid) vcnt++;
    if (fail)  fcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_seed(input logic [6:0] s);
    @(negedge clk); seed_load = 1'b1; seed = s;
    @(negedge clk); seed_load = 1'b0; seed = '0;
  endtask

  task automatic request(input bit which, input logic [6:0] s, input bit interfere,
                         output bit got_v, output bit got_f, output int cyc, output int steps);
    int s0;
    logic done_now;
    s0 = which ? step_cnt4 : step_cnt;
    @(negedge clk); enable = 1'b1; score = s;
    @(negedge clk); enable = 1'b0;
    chk("busy_after_start", 32'(which ? busy4 : busy), 32'd1);
    got_v = 1'b0; got_f = 1'b0; cyc = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      done_now = which ? (valid4 | fail4) : (valid | fail);
      if (done_now) begin
        got_v = which ? valid4 : valid;
        got_f = which ? fail4 : fail;
        cyc = i;
        chk("busy_at_done", 32'(which ? busy4 : busy), 32'd0);
        break;
      end
      if (interfere) begin
        enable    = (i < 6) && (i % 2 == 1);
        seed_load = (i < 6) && (i % 2 == 1);
        seed      = 7'h55;
        score     = 7'd2;
      end
    end
    enable = 1'b0; seed_load = 1'b0;
    chk("no_timeout", 32'(cyc != 0), 32'd1);
    steps = (which ? step_cnt4 : step_cnt) - s0;
    @(negedge clk);
    chk("pulse_one_cycle", 32'(which ? (valid4 | fail4) : (valid | fail)), 32'd0);
  endtask

  initial begin
    bit gv, gf;
    int cyc, steps, v0, f0, found;
    rst = 1'b1; enable = 1'b0; score = '0; seed_load = 1'b0; seed = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_prime", 32'(prime), 32'd0);
    rst = 1'b0;

    // Seed 1, bound 15: 96,48,24,12,6,3 -> 3
    v0 = vcnt;
    request(1'b0, 7'd15, 1'b0, gv, gf, cyc, steps);
    chk("a_valid", 32'(gv), 32'd1);
    chk("a_fail", 32'(gf), 32'd0);
    chk("a_prime", 32'(prime), 32'd3);
    chk("a_steps", 32'(steps), 32'd6);
    chk("a_valid_count", 32'(vcnt - v0), 32'd1);

    // Continue from 3 -> 97, while enable/seed_load/score are wiggled mid-request
    v0 = vcnt;
    request(1'b0, 7'd127, 1'b1, gv, gf, cyc, steps);
    chk("b_valid", 32'(gv), 32'd1);
    chk("b_prime", 32'(prime), 32'd97);
    chk("b_steps", 32'(steps), 32'd1);
    chk("b_valid_count", 32'(vcnt - v0), 32'd1);

    // Seed 0 maps to 1, so the first sequence repeats
    load_seed(7'd0);
    request(1'b0, 7'd15, 1'b0, gv, gf, cyc, steps);
    chk("d_prime", 32'(prime), 32'd3);
    chk("d_steps", 32'(steps), 32'd6);

    load_seed(7'd3);
    request(1'b0, 7'd127, 1'b0, gv, gf, cyc, steps);
    chk("c_valid", 32'(gv), 32'd1);
    chk("c_prime", 32'(prime), 32'd97);
    chk("c_steps", 32'(steps), 32'd1);

    // Bound below 2 fails immediately
    request(1'b0, 7'd1, 1'b0, gv, gf, cyc, steps);
    chk("e_fail", 32'(gf), 32'd1);
    chk("e_valid", 32'(gv), 32'd0);
    chk("e_latency", 32'(cyc), 32'd2);
    chk("e_prime_held", 32'(prime), 32'd97);
    chk("e_steps", 32'(steps), 32'd0);

    // From 97: 80 is composite, so the divider is reached; reset there
    v0 = vcnt; f0 = fcnt; found = 0;
    @(negedge clk); enable = 1'b1; score = 7'd127;
    @(negedge clk); enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dut.state_reg == DIV_SUB) begin found = 1; break; end
      @(negedge clk);
    end
    chk("f_reached_div_sub", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("f_state_idle", 32'(dut.state_reg == IDLE), 32'd1);
    chk("f_lfsr_seed", 32'(dut.lfsr_val), 32'd1);
    chk("f_busy", 32'(busy), 32'd0);
    chk("f_valid", 32'(valid), 32'd0);
    chk("f_fail", 32'(fail), 32'd0);
    chk("f_prime", 32'(prime), 32'd0);
    repeat (3) @(negedge clk);
    chk("f_no_pulses", 32'((vcnt - v0) + (fcnt - f0)), 32'd0);
    request(1'b0, 7'd15, 1'b0, gv, gf, cyc, steps);
    chk("f_after_prime", 32'(prime), 32'd3);
    chk("f_after_steps", 32'(steps), 32'd6);

    // Four-try instance: get 97 first, then exhaust the budget
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    load_seed(7'd3);
    request(1'b1, 7'd127, 1'b0, gv, gf, cyc, steps);
    chk("g_first_prime", 32'(prime4), 32'd97);
    load_seed(7'd1);
    request(1'b1, 7'd15, 1'b0, gv, gf, cyc, steps);
    chk("g_fail", 32'(gf), 32'd1);
    chk("g_valid", 32'(gv), 32'd0);
    chk("g_steps", 32'(steps), 32'd4);
    chk("g_prime_held", 32'(prime4), 32'd97);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
